// File: rtl/rename_dispatch_ss_pkg.sv
// Shared widths, bundle/entry structs and the needs_pr helper for the
// superscalar rename/dispatch stage.
package rename_dispatch_ss_pkg;
   localparam int SS         = 2;
   localparam int PR_ENTRIES = 64;
   localparam int PR_W       = $clog2(PR_ENTRIES);
   localparam int ROB_DEPTH  = 16;
   localparam int RID_W      = $clog2(ROB_DEPTH);
   localparam int CNT_W      = $clog2(SS + 1);

   typedef logic [CNT_W-1:0] dispatch_cnt_t;
   typedef logic [RID_W-1:0] rob_id_t;
   typedef logic [PR_W-1:0]  pr_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rs1_s;
      logic [4:0]  rs2_s;
      logic [4:0]  rd_s;
      logic        has_rd;
      logic        rs1_is_reg;
      logic        rs2_is_reg;
      logic        is_branch;
      logic [3:0]  wmask;
   } inst_t;

   typedef struct packed {
      logic [63:0] order;
      logic [31:0] pc;
      rob_id_t     rob_id;
      pr_t         rs1_pr;
      pr_t         rs2_pr;
      pr_t         rd_pr;
      rob_id_t     rs1_source;
      rob_id_t     rs2_source;
      logic        input1_met;
      logic        input2_met;
      logic [4:0]  rd_s;
      logic        has_rd;
      logic        is_branch;
      logic [3:0]  wmask;
   } super_dispatch_t;

   function automatic logic needs_pr(input inst_t inst);
      return inst.has_rd && (inst.rd_s != 5'd0);
   endfunction
endpackage

// File: rtl/rename_dispatch_ss_if.sv
// Registered output stage of rename/dispatch towards the RS/ROB.
interface rename_dispatch_ss_if;
   import rename_dispatch_ss_pkg::*;

   logic [SS-1:0]            out_valid;
   super_dispatch_t [SS-1:0] out_entry;
   logic                     out_ready;

   modport master (output out_valid, output out_entry, input out_ready);
   modport slave  (input out_valid, input out_entry, output out_ready);
endinterface

// File: rtl/rename_dispatch_ss_bypass_net.sv
// Intra-bundle source override: for each slot/source, the nearest earlier
// slot that allocates a new PR for the same architectural register.
module rename_dispatch_ss_bypass_net
   import rename_dispatch_ss_pkg::*;
(
   input  logic [SS-1:0][4:0] i_rd,
   input  logic [SS-1:0][4:0] i_rs1,
   input  logic [SS-1:0][4:0] i_rs2,
   input  logic [SS-1:0]      i_needs,
   input  pr_t  [SS-1:0]      i_new_pr,
   input  rob_id_t [SS-1:0]   i_rob_id,
   output logic [SS-1:0]      o_hit1,
   output logic [SS-1:0]      o_hit2,
   output pr_t  [SS-1:0]      o_pr1,
   output pr_t  [SS-1:0]      o_pr2,
   output rob_id_t [SS-1:0]   o_rid1,
   output rob_id_t [SS-1:0]   o_rid2
);
   always_comb begin
      o_hit1 = '0;
      o_hit2 = '0;
      o_pr1  = '0;
      o_pr2  = '0;
      o_rid1 = '0;
      o_rid2 = '0;
      // Ascending producer scan: the nearest earlier writer overwrites older matches.
      for (int j = 0; j < SS; j++) begin
         for (int i = 0; i < j; i++) begin
            if (i_needs[i] && (i_rd[i] == i_rs1[j])) begin
               o_hit1[j] = 1'b1;
               o_pr1[j]  = i_new_pr[i];
               o_rid1[j] = i_rob_id[i];
            end
            if (i_needs[i] && (i_rd[i] == i_rs2[j])) begin
               o_hit2[j] = 1'b1;
               o_pr2[j]  = i_new_pr[i];
               o_rid2[j] = i_rob_id[i];
            end
         end
      end
   end
endmodule

// File: rtl/rename_dispatch_ss.sv
// Superscalar rename/dispatch: accepts the longest credit-fitting prefix of the
// head bundle, renames it (with intra-bundle bypass) into one registered stage.
module rename_dispatch_ss
   import rename_dispatch_ss_pkg::*;
#(
   parameter bit STORE_SERIAL = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_flush,
   input  logic [63:0]          i_flush_order,
   input  logic [SS-1:0]        i_in_valid,
   input  inst_t [SS-1:0]       i_in_inst,
   output dispatch_cnt_t        o_acc_cnt,
   input  dispatch_cnt_t        i_rs_credit,
   input  dispatch_cnt_t        i_rob_credit,
   input  dispatch_cnt_t        i_fl_credit,
   input  rob_id_t              i_rob_id_base,
   output logic [SS-1:0][4:0]   o_isa_rs1,
   output logic [SS-1:0][4:0]   o_isa_rs2,
   input  pr_t [SS-1:0]         i_rat_rs1,
   input  pr_t [SS-1:0]         i_rat_rs2,
   input  logic [SS-1:0]        i_src_dep1,
   input  logic [SS-1:0]        i_src_dep2,
   input  rob_id_t [SS-1:0]     i_src_rid1,
   input  rob_id_t [SS-1:0]     i_src_rid2,
   output logic [SS-1:0]        o_fl_pop,
   input  pr_t [SS-1:0]         i_fl_pr,
   output logic [SS-1:0]        o_rat_we,
   output logic [SS-1:0][4:0]   o_rat_wa,
   output pr_t [SS-1:0]         o_rat_wd,
   rename_dispatch_ss_if.master io_disp
);
   logic [SS-1:0]            w_needs;
   logic [SS-1:0]            w_acc;
   logic [SS-1:0][4:0]       w_rd;
   logic [SS-1:0][4:0]       w_rs1;
   logic [SS-1:0][4:0]       w_rs2;
   pr_t [SS-1:0]             w_new_pr;
   rob_id_t [SS-1:0]         w_rob_id;
   logic [SS-1:0]            w_hit1, w_hit2;
   pr_t [SS-1:0]             w_byp_pr1, w_byp_pr2;
   rob_id_t [SS-1:0]         w_byp_rid1, w_byp_rid2;
   dispatch_cnt_t            w_n;
   dispatch_cnt_t            w_n_eff;
   logic                     w_load_en;
   super_dispatch_t [SS-1:0] w_entry;

   logic [SS-1:0]            r_out_valid;
   super_dispatch_t [SS-1:0] r_out_entry;
   logic [63:0]              r_order;

   // Per-slot decode: free PRs are handed out in slot order to needs_pr slots only.
   always_comb begin
      dispatch_cnt_t k;
      k        = '0;
      w_needs  = '0;
      w_new_pr = '0;
      w_rob_id = '0;
      w_rd     = '0;
      w_rs1    = '0;
      w_rs2    = '0;
      for (int i = 0; i < SS; i++) begin
         w_needs[i]  = needs_pr(i_in_inst[i]);
         w_rd[i]     = i_in_inst[i].rd_s;
         w_rs1[i]    = i_in_inst[i].rs1_s;
         w_rs2[i]    = i_in_inst[i].rs2_s;
         w_rob_id[i] = i_rob_id_base + RID_W'(i);
         for (int m = 0; m < SS; m++) begin
            if (k == CNT_W'(m)) w_new_pr[i] = i_fl_pr[m];
         end
         k = k + dispatch_cnt_t'(w_needs[i]);
      end
   end

   always_comb begin
      logic ok;
      int   prs;
      int   st;
      ok  = 1'b1;
      prs = 0;
      st  = 0;
      w_n = '0;
      for (int i = 0; i < SS; i++) begin
         prs = prs + int'(w_needs[i]);
         st  = st + int'(i_in_inst[i].wmask != 4'd0);
         if (ok && i_in_valid[i] && (i + 1 <= int'(i_rs_credit)) &&
             (i + 1 <= int'(i_rob_credit)) && (prs <= int'(i_fl_credit)) &&
             (!STORE_SERIAL || st <= 1))
            w_n = dispatch_cnt_t'(i + 1);
         else
            ok = 1'b0;
      end
   end

   assign w_load_en = !rst && !i_flush && (io_disp.out_ready || !(|r_out_valid));
   assign w_n_eff   = w_load_en ? w_n : '0;
   assign o_acc_cnt = w_n_eff;

   rename_dispatch_ss_bypass_net u_rename_bypass_net (
      .i_rd     (w_rd),
      .i_rs1    (w_rs1),
      .i_rs2    (w_rs2),
      .i_needs  (w_needs),
      .i_new_pr (w_new_pr),
      .i_rob_id (w_rob_id),
      .o_hit1   (w_hit1),
      .o_hit2   (w_hit2),
      .o_pr1    (w_byp_pr1),
      .o_pr2    (w_byp_pr2),
      .o_rid1   (w_byp_rid1),
      .o_rid2   (w_byp_rid2)
   );

   always_comb begin
      w_acc     = '0;
      o_fl_pop  = '0;
      o_rat_we  = '0;
      o_rat_wa  = '0;
      o_rat_wd  = '0;
      o_isa_rs1 = '0;
      o_isa_rs2 = '0;
      w_entry   = '0;
      for (int i = 0; i < SS; i++) w_acc[i] = CNT_W'(i) < w_n_eff;
      for (int i = 0; i < SS; i++) begin
         o_fl_pop[i] = w_acc[i] && w_needs[i];
         o_rat_we[i] = o_fl_pop[i];
         // A later accepted writer of the same rd owns the RAT entry.
         for (int j = i + 1; j < SS; j++) begin
            if (w_acc[j] && w_needs[j] && (w_rd[j] == w_rd[i])) o_rat_we[i] = 1'b0;
         end
         if (!rst) begin
            o_rat_wa[i]  = w_rd[i];
            o_rat_wd[i]  = w_new_pr[i];
            o_isa_rs1[i] = w_rs1[i];
            o_isa_rs2[i] = w_rs2[i];
         end
         w_entry[i].order      = r_order + 64'(i);
         w_entry[i].pc         = i_in_inst[i].pc;
         w_entry[i].rob_id     = w_rob_id[i];
         w_entry[i].rd_pr      = w_needs[i] ? w_new_pr[i] : '0;
         w_entry[i].rs1_pr     = w_hit1[i] ? w_byp_pr1[i] : i_rat_rs1[i];
         w_entry[i].rs2_pr     = w_hit2[i] ? w_byp_pr2[i] : i_rat_rs2[i];
         w_entry[i].rs1_source = w_hit1[i] ? w_byp_rid1[i] : i_src_rid1[i];
         w_entry[i].rs2_source = w_hit2[i] ? w_byp_rid2[i] : i_src_rid2[i];
         w_entry[i].input1_met = w_hit1[i] ? 1'b0 :
            ((i_in_inst[i].rs1_is_reg || i_in_inst[i].is_branch) ? !i_src_dep1[i] : 1'b1);
         w_entry[i].input2_met = w_hit2[i] ? 1'b0 :
            ((i_in_inst[i].rs2_is_reg || i_in_inst[i].is_branch) ? !i_src_dep2[i] : 1'b1);
         w_entry[i].rd_s       = w_rd[i];
         w_entry[i].has_rd     = i_in_inst[i].has_rd;
         w_entry[i].is_branch  = i_in_inst[i].is_branch;
         w_entry[i].wmask      = i_in_inst[i].wmask;
      end
   end

   // Output stage: control is reset, payload only follows load_en.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= '0;
         r_order     <= '0;
      end else if (i_flush) begin
         r_out_valid <= '0;
         r_order     <= i_flush_order;
      end else if (w_load_en) begin
         r_out_valid <= w_acc;
         r_order     <= r_order + 64'(w_n);
      end
   end

   always_ff @(posedge clk) begin
      if (w_load_en) r_out_entry <= w_entry;
   end

   assign io_disp.out_valid = r_out_valid;
   assign io_disp.out_entry = r_out_entry;
endmodule

// File: tb/tb_rename_dispatch_ss.sv
// Scenario bench for rename_dispatch_ss: expected entries are queued on acceptance
// and compared when the output stage hands them off.
`timescale 1ns/1ps
module tb_rename_dispatch_ss;
   import rename_dispatch_ss_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic               flush;
   logic [63:0]        flush_order;
   logic [SS-1:0]      in_valid;
   inst_t [SS-1:0]     in_inst;
   dispatch_cnt_t      acc_cnt, rs_credit, rob_credit, fl_credit;
   rob_id_t            rob_id_base;
   logic [SS-1:0][4:0] isa_rs1, isa_rs2, rat_wa;
   pr_t [SS-1:0]       rat_rs1, rat_rs2, fl_pr, rat_wd;
   logic [SS-1:0]      src_dep1, src_dep2, fl_pop, rat_we;
   rob_id_t [SS-1:0]   src_rid1, src_rid2;

   rename_dispatch_ss_if dif ();

   rename_dispatch_ss #(.STORE_SERIAL(1'b1)) dut (
      .clk(clk), .rst(rst), .i_flush(flush), .i_flush_order(flush_order),
      .i_in_valid(in_valid), .i_in_inst(in_inst), .o_acc_cnt(acc_cnt),
      .i_rs_credit(rs_credit), .i_rob_credit(rob_credit), .i_fl_credit(fl_credit),
      .i_rob_id_base(rob_id_base), .o_isa_rs1(isa_rs1), .o_isa_rs2(isa_rs2),
      .i_rat_rs1(rat_rs1), .i_rat_rs2(rat_rs2), .i_src_dep1(src_dep1), .i_src_dep2(src_dep2),
      .i_src_rid1(src_rid1), .i_src_rid2(src_rid2), .o_fl_pop(fl_pop), .i_fl_pr(fl_pr),
      .o_rat_we(rat_we), .o_rat_wa(rat_wa), .o_rat_wd(rat_wd), .io_disp(dif)
   );

   typedef struct packed {
      logic [63:0] order;
      rob_id_t     rob_id;
      pr_t         rd_pr;
      pr_t         rs1_pr;
      rob_id_t     rs1_src;
      logic        met1;
   } slot_exp_t;

   typedef struct packed {
      logic [SS-1:0]      vld;
      slot_exp_t [SS-1:0] s;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   function automatic inst_t mk(input logic hrd, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic rs1_reg, input logic [3:0] wm);
      inst_t t;
      t            = '0;
      t.pc         = 32'h1000;
      t.has_rd     = hrd;
      t.rd_s       = rd;
      t.rs1_s      = rs1;
      t.rs1_is_reg = rs1_reg;
      t.wmask      = wm;
      return t;
   endfunction

   function automatic slot_exp_t se(input logic [63:0] ord, input rob_id_t rid, input pr_t rdp,
                                    input pr_t r1p, input rob_id_t r1s, input logic m1);
      slot_exp_t e;
      e.order   = ord;
      e.rob_id  = rid;
      e.rd_pr   = rdp;
      e.rs1_pr  = r1p;
      e.rs1_src = r1s;
      e.met1    = m1;
      return e;
   endfunction

   // Scoreboard consumer: one pop per output-stage handshake.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (|dif.out_valid) && dif.out_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got out_valid=%b, required no output", dif.out_valid);
         end else begin
            e = sb.pop_front();
            if (dif.out_valid !== e.vld) begin
               bad++;
               $display("FAIL sb_valid: got %b want %b", dif.out_valid, e.vld);
            end
            for (int i = 0; i < SS; i++) begin
               if (e.vld[i]) begin
                  total++;
                  if (dif.out_entry[i].order !== e.s[i].order ||
                      dif.out_entry[i].rob_id !== e.s[i].rob_id ||
                      dif.out_entry[i].rd_pr !== e.s[i].rd_pr ||
                      dif.out_entry[i].rs1_pr !== e.s[i].rs1_pr ||
                      dif.out_entry[i].rs1_source !== e.s[i].rs1_src ||
                      dif.out_entry[i].input1_met !== e.s[i].met1) begin
                     bad++;
                     $display("FAIL sb_entry%0d: got ord=%0d rid=%0d rd=%0d rs1=%0d src=%0d met=%b want ord=%0d rid=%0d rd=%0d rs1=%0d src=%0d met=%b",
                        i, dif.out_entry[i].order, dif.out_entry[i].rob_id, dif.out_entry[i].rd_pr,
                        dif.out_entry[i].rs1_pr, dif.out_entry[i].rs1_source, dif.out_entry[i].input1_met,
                        e.s[i].order, e.s[i].rob_id, e.s[i].rd_pr, e.s[i].rs1_pr, e.s[i].rs1_src, e.s[i].met1);
                  end
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid      = '0;
      flush         = 1'b0;
      dif.out_ready = 1'b1;
      rs_credit     = 2'd2;
      rob_credit    = 2'd2;
      fl_credit     = 2'd2;
      fl_pr         = {6'd41, 6'd40};
      src_dep1      = '0;
      tick();
   endtask

   task automatic test_reset();
      exp_t e;
      rst = 1'b1;
      in_valid = 2'b11;
      in_inst[0] = mk(1'b1, 5'd1, 5'd2, 1'b1, 4'd0);
      in_inst[1] = mk(1'b1, 5'd2, 5'd4, 1'b1, 4'd0);
      repeat (2) tick();
      total++; if (dif.out_valid !== 2'b00) begin bad++; $display("FAIL rst_out_valid: got %b want 00", dif.out_valid); end
      total++; if (acc_cnt !== 2'd0) begin bad++; $display("FAIL rst_acc_cnt: got %0d want 0", acc_cnt); end
      total++; if (rat_we !== 2'b00) begin bad++; $display("FAIL rst_rat_we: got %b want 00", rat_we); end
      total++; if (fl_pop !== 2'b00) begin bad++; $display("FAIL rst_fl_pop: got %b want 00", fl_pop); end
      total++; if (isa_rs1 !== 10'd0) begin bad++; $display("FAIL rst_isa_rs1: got %h want 0", isa_rs1); end
      rst = 1'b0;
      in_valid = 2'b00;
      tick();
      src_dep1 = 2'b01;
      rob_id_base = 4'd3;
      in_valid = 2'b11;
      #1;
      total++; if (acc_cnt !== 2'd2) begin bad++; $display("FAIL first_acc: got %0d want 2", acc_cnt); end
      total++; if (fl_pop !== 2'b11) begin bad++; $display("FAIL first_fl_pop: got %b want 11", fl_pop); end
      total++; if (rat_we !== 2'b11) begin bad++; $display("FAIL first_rat_we: got %b want 11", rat_we); end
      total++; if (rat_wd !== {6'd41, 6'd40}) begin bad++; $display("FAIL first_rat_wd: got %h want %h", rat_wd, {6'd41, 6'd40}); end
      total++; if (rat_wa !== {5'd2, 5'd1}) begin bad++; $display("FAIL first_rat_wa: got %h want %h", rat_wa, {5'd2, 5'd1}); end
      total++; if (isa_rs1 !== {5'd4, 5'd2}) begin bad++; $display("FAIL first_isa_rs1: got %h want %h", isa_rs1, {5'd4, 5'd2}); end
      e.vld = 2'b11;
      e.s[0] = se(64'd0, 4'd3, 6'd40, 6'd20, 4'd7, 1'b0);
      e.s[1] = se(64'd1, 4'd4, 6'd41, 6'd21, 4'd8, 1'b1);
      sb.push_back(e);
      tick();
      idle();
   endtask

   task automatic test_bypass_wrap();
      exp_t e;
      rob_id_base = 4'd15;
      in_inst[0] = mk(1'b1, 5'd5, 5'd1, 1'b1, 4'd0);
      in_inst[1] = mk(1'b1, 5'd6, 5'd5, 1'b1, 4'd0);
      in_valid = 2'b11;
      #1;
      total++; if (acc_cnt !== 2'd2) begin bad++; $display("FAIL byp_acc: got %0d want 2", acc_cnt); end
      e.vld = 2'b11;
      e.s[0] = se(64'd2, 4'd15, 6'd40, 6'd20, 4'd7, 1'b1);
      e.s[1] = se(64'd3, 4'd0, 6'd41, 6'd40, 4'd15, 1'b0);
      sb.push_back(e);
      tick();
      idle();
   endtask

   task automatic test_fl_credit();
      exp_t e;
      fl_credit = 2'd1;
      rob_id_base = 4'd0;
      in_inst[0] = mk(1'b1, 5'd3, 5'd0, 1'b0, 4'd0);
      in_inst[1] = mk(1'b1, 5'd4, 5'd0, 1'b0, 4'd0);
      in_valid = 2'b11;
      #1;
      total++; if (acc_cnt !== 2'd1) begin bad++; $display("FAIL flc_acc: got %0d want 1", acc_cnt); end
      total++; if (fl_pop !== 2'b01) begin bad++; $display("FAIL flc_fl_pop: got %b want 01", fl_pop); end
      total++; if (rat_we !== 2'b01) begin bad++; $display("FAIL flc_rat_we: got %b want 01", rat_we); end
      e = '0;
      e.vld = 2'b01;
      e.s[0] = se(64'd4, 4'd0, 6'd40, 6'd20, 4'd7, 1'b1);
      sb.push_back(e);
      tick();
      in_inst[0] = mk(1'b1, 5'd4, 5'd0, 1'b0, 4'd0);
      in_valid = 2'b01;
      rob_id_base = 4'd1;
      fl_pr = {6'd42, 6'd41};
      #1;
      total++; if (acc_cnt !== 2'd1) begin bad++; $display("FAIL flc_retry_acc: got %0d want 1", acc_cnt); end
      total++; if (rat_wa[0] !== 5'd4) begin bad++; $display("FAIL flc_retry_wa: got %0d want 4", rat_wa[0]); end
      e = '0;
      e.vld = 2'b01;
      e.s[0] = se(64'd5, 4'd1, 6'd41, 6'd20, 4'd7, 1'b1);
      sb.push_back(e);
      tick();
      idle();
   endtask

   task automatic test_store_serial();
      exp_t e;
      rob_id_base = 4'd2;
      in_inst[0] = mk(1'b0, 5'd0, 5'd1, 1'b1, 4'hf);
      in_inst[1] = mk(1'b0, 5'd0, 5'd2, 1'b1, 4'h3);
      in_valid = 2'b11;
      #1;
      total++; if (acc_cnt !== 2'd1) begin bad++; $display("FAIL st_acc: got %0d want 1", acc_cnt); end
      total++; if (fl_pop !== 2'b00) begin bad++; $display("FAIL st_fl_pop: got %b want 00", fl_pop); end
      e = '0;
      e.vld = 2'b01;
      e.s[0] = se(64'd6, 4'd2, 6'd0, 6'd20, 4'd7, 1'b1);
      sb.push_back(e);
      tick();
      in_inst[0] = mk(1'b0, 5'd0, 5'd2, 1'b1, 4'h3);
      in_valid = 2'b01;
      rob_id_base = 4'd3;
      #1;
      total++; if (acc_cnt !== 2'd1) begin bad++; $display("FAIL st_second_acc: got %0d want 1", acc_cnt); end
      e = '0;
      e.vld = 2'b01;
      e.s[0] = se(64'd7, 4'd3, 6'd0, 6'd20, 4'd7, 1'b1);
      sb.push_back(e);
      tick();
      in_inst[0] = mk(1'b0, 5'd0, 5'd1, 1'b1, 4'hf);
      in_inst[1] = mk(1'b1, 5'd9, 5'd0, 1'b0, 4'd0);
      in_valid = 2'b11;
      rob_id_base = 4'd4;
      #1;
      total++; if (acc_cnt !== 2'd2) begin bad++; $display("FAIL st_alu_acc: got %0d want 2", acc_cnt); end
      total++; if (fl_pop !== 2'b10) begin bad++; $display("FAIL st_alu_pop: got %b want 10", fl_pop); end
      total++; if (rat_wd[1] !== 6'd40) begin bad++; $display("FAIL st_alu_wd: got %0d want 40", rat_wd[1]); end
      e.vld = 2'b11;
      e.s[0] = se(64'd8, 4'd4, 6'd0, 6'd20, 4'd7, 1'b1);
      e.s[1] = se(64'd9, 4'd5, 6'd40, 6'd21, 4'd8, 1'b1);
      sb.push_back(e);
      tick();
      idle();
   endtask

   task automatic test_backpressure();
      exp_t e;
      dif.out_ready = 1'b0;
      rob_id_base = 4'd6;
      in_inst[0] = mk(1'b1, 5'd10, 5'd0, 1'b0, 4'd0);
      in_inst[1] = mk(1'b1, 5'd11, 5'd0, 1'b0, 4'd0);
      in_valid = 2'b11;
      #1;
      total++; if (acc_cnt !== 2'd2) begin bad++; $display("FAIL bp_load_acc: got %0d want 2", acc_cnt); end
      e.vld = 2'b11;
      e.s[0] = se(64'd10, 4'd6, 6'd40, 6'd20, 4'd7, 1'b1);
      e.s[1] = se(64'd11, 4'd7, 6'd41, 6'd21, 4'd8, 1'b1);
      sb.push_back(e);
      tick();
      rob_id_base = 4'd8;
      in_inst[0] = mk(1'b1, 5'd12, 5'd0, 1'b0, 4'd0);
      in_inst[1] = mk(1'b1, 5'd13, 5'd0, 1'b0, 4'd0);
      for (int c = 0; c < 3; c++) begin
         #1;
         total++; if (dif.out_valid !== 2'b11) begin bad++; $display("FAIL bp_hold_valid c%0d: got %b want 11", c, dif.out_valid); end
         total++; if (acc_cnt !== 2'd0) begin bad++; $display("FAIL bp_hold_acc c%0d: got %0d want 0", c, acc_cnt); end
         total++; if (fl_pop !== 2'b00 || rat_we !== 2'b00) begin bad++; $display("FAIL bp_hold_pop c%0d: got pop=%b we=%b want 00", c, fl_pop, rat_we); end
         total++; if (dif.out_entry[0].order !== 64'd10) begin bad++; $display("FAIL bp_hold_order c%0d: got %0d want 10", c, dif.out_entry[0].order); end
         tick();
      end
      dif.out_ready = 1'b1;
      #1;
      total++; if (acc_cnt !== 2'd2) begin bad++; $display("FAIL bp_release_acc: got %0d want 2", acc_cnt); end
      e.s[0] = se(64'd12, 4'd8, 6'd40, 6'd20, 4'd7, 1'b1);
      e.s[1] = se(64'd13, 4'd9, 6'd41, 6'd21, 4'd8, 1'b1);
      sb.push_back(e);
      tick();
   endtask

   task automatic test_flush();
      exp_t e;
      flush = 1'b1;
      flush_order = 64'd42;
      in_inst[0] = mk(1'b1, 5'd20, 5'd0, 1'b0, 4'd0);
      in_inst[1] = mk(1'b1, 5'd21, 5'd0, 1'b0, 4'd0);
      in_valid = 2'b11;
      #1;
      total++; if (acc_cnt !== 2'd0) begin bad++; $display("FAIL fl_acc: got %0d want 0", acc_cnt); end
      total++; if (fl_pop !== 2'b00 || rat_we !== 2'b00) begin bad++; $display("FAIL fl_pop: got pop=%b we=%b want 00", fl_pop, rat_we); end
      tick();
      flush = 1'b0;
      total++; if (dif.out_valid !== 2'b00) begin bad++; $display("FAIL fl_out_valid: got %b want 00", dif.out_valid); end
      rob_id_base = 4'd10;
      #1;
      total++; if (acc_cnt !== 2'd2) begin bad++; $display("FAIL fl_after_acc: got %0d want 2", acc_cnt); end
      e.vld = 2'b11;
      e.s[0] = se(64'd42, 4'd10, 6'd40, 6'd20, 4'd7, 1'b1);
      e.s[1] = se(64'd43, 4'd11, 6'd41, 6'd21, 4'd8, 1'b1);
      sb.push_back(e);
      tick();
   endtask

   task automatic test_same_rd();
      exp_t e;
      rob_id_base = 4'd12;
      in_inst[0] = mk(1'b1, 5'd7, 5'd0, 1'b0, 4'd0);
      in_inst[1] = mk(1'b1, 5'd7, 5'd0, 1'b0, 4'd0);
      in_valid = 2'b11;
      #1;
      total++; if (rat_we !== 2'b10) begin bad++; $display("FAIL same_rat_we: got %b want 10", rat_we); end
      total++; if (rat_wd[1] !== 6'd41) begin bad++; $display("FAIL same_rat_wd: got %0d want 41", rat_wd[1]); end
      total++; if (rat_wa[1] !== 5'd7) begin bad++; $display("FAIL same_rat_wa: got %0d want 7", rat_wa[1]); end
      total++; if (fl_pop !== 2'b11) begin bad++; $display("FAIL same_fl_pop: got %b want 11", fl_pop); end
      e.vld = 2'b11;
      e.s[0] = se(64'd44, 4'd12, 6'd40, 6'd20, 4'd7, 1'b1);
      e.s[1] = se(64'd45, 4'd13, 6'd41, 6'd21, 4'd8, 1'b1);
      sb.push_back(e);
      tick();
   endtask

   task automatic test_credits();
      exp_t e;
      in_valid = 2'b10;
      #1;
      total++; if (acc_cnt !== 2'd0 || fl_pop !== 2'b00) begin bad++; $display("FAIL hole: got acc=%0d pop=%b want 0/00", acc_cnt, fl_pop); end
      tick();
      in_valid = 2'b11;
      rs_credit = 2'd1;
      rob_id_base = 4'd14;
      in_inst[0] = mk(1'b1, 5'd16, 5'd0, 1'b0, 4'd0);
      #1;
      total++; if (acc_cnt !== 2'd1) begin bad++; $display("FAIL rs_credit1: got %0d want 1", acc_cnt); end
      e = '0;
      e.vld = 2'b01;
      e.s[0] = se(64'd46, 4'd14, 6'd40, 6'd20, 4'd7, 1'b1);
      sb.push_back(e);
      tick();
      rs_credit = 2'd2;
      rob_credit = 2'd0;
      #1;
      total++; if (acc_cnt !== 2'd0) begin bad++; $display("FAIL rob_credit0: got %0d want 0", acc_cnt); end
      tick();
      rob_credit = 2'd2;
      fl_credit = 2'd0;
      rob_id_base = 4'd15;
      in_inst[0] = mk(1'b0, 5'd0, 5'd3, 1'b1, 4'd0);
      in_inst[1] = mk(1'b1, 5'd0, 5'd0, 1'b0, 4'd0);
      #1;
      total++; if (acc_cnt !== 2'd2) begin bad++; $display("FAIL x0_acc: got %0d want 2", acc_cnt); end
      total++; if (fl_pop !== 2'b00 || rat_we !== 2'b00) begin bad++; $display("FAIL x0_pop: got pop=%b we=%b want 00", fl_pop, rat_we); end
      e.vld = 2'b11;
      e.s[0] = se(64'd47, 4'd15, 6'd0, 6'd20, 4'd7, 1'b1);
      e.s[1] = se(64'd48, 4'd0, 6'd0, 6'd21, 4'd8, 1'b1);
      sb.push_back(e);
      tick();
      idle();
   endtask

   initial begin
      flush         = 1'b0;
      flush_order   = '0;
      in_valid      = '0;
      in_inst       = '0;
      rs_credit     = 2'd2;
      rob_credit    = 2'd2;
      fl_credit     = 2'd2;
      rob_id_base   = '0;
      rat_rs1       = {6'd21, 6'd20};
      rat_rs2       = {6'd31, 6'd30};
      src_dep1      = '0;
      src_dep2      = '0;
      src_rid1      = {4'd8, 4'd7};
      src_rid2      = {4'd10, 4'd9};
      fl_pr         = {6'd41, 6'd40};
      dif.out_ready = 1'b1;

      test_reset();
      test_bypass_wrap();
      test_fl_credit();
      test_store_serial();
      test_backpressure();
      test_flush();
      test_same_rd();
      test_credits();
      repeat (3) tick();

      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: got %0d pending want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
